// File: rtl/noc_arb_pkg.sv
// Shared definitions for the mesh-router output-port arbiters: port index
// names, the default requester count, the arbiter state type and a helper
// that sizes binary channel indices.
package noc_arb_pkg;

  localparam int LOCAL = 0;
  localparam int NORTH = 1;
  localparam int EAST  = 2;
  localparam int SOUTH = 3;
  localparam int WEST  = 4;

  localparam int DEFAULT_NUM_REQ = 5;

  // The arbiter state is carried by gnt_valid/gnt_id; this names the two cases.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Width of a binary channel index for num_req channels (at least 1 bit).
  function automatic int id_width(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority picker: returns the first masked request
// found scanning from ptr upward with wrap-around. Built as rotate so that
// ptr lands on bit 0, a plain lowest-index priority encode, then un-rotate.
module rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] win,
  output logic [ID_W-1:0]    win_id,
  output logic               any
);

  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] rotated;
  logic [ID_W-1:0]    rot_idx;

  assign masked = req & mask;

  // Rotate the masked requests so that channel ptr sits at bit 0.
  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rotated[i] = masked[(i + int'(ptr)) % NUM_REQ];
    end
  end

  // Lowest set bit of the rotated vector is the winner in scan order.
  always_comb begin
    rot_idx = '0;
    any     = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        rot_idx = ID_W'(i);
        any     = 1'b1;
      end
    end
  end

  // Undo the rotation to recover the real channel index and one-hot grant.
  always_comb begin
    win_id = ID_W'((int'(rot_idx) + int'(ptr)) % NUM_REQ);
    win    = '0;
    if (any) begin
      win[win_id] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_hold_arbiter.sv
// Hold-until-release arbiter for one router output port. A granted channel
// keeps the port while its request stays high so packets are never
// interleaved; selection is round-robin or fixed priority, and a bounded
// hold time forcibly rotates an owner that starves other waiting channels.
module rr_hold_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_REQ,
  parameter int ID_W     = id_width(DEFAULT_NUM_REQ),
  parameter int MAX_HOLD = 16,
  parameter int RR_MODE  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               preempt
);

  localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  // Successor channel index with wrap-around.
  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] j);
    return (int'(j) >= NUM_REQ - 1) ? '0 : j + 1'b1;
  endfunction

  arb_state_e         state;
  logic [ID_W-1:0]    ptr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [ID_W-1:0]    pick_ptr;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] win;
  logic [ID_W-1:0]    win_id;
  logic               any;
  logic               released;
  logic               at_limit;
  logic               do_grant;
  logic               do_preempt;

  assign state    = gnt_valid ? ST_OWN : ST_IDLE;
  // gnt is one-hot, so the owner has released when its bit of req is low.
  assign released = ((req & gnt) == '0);
  // While owning, the owner is excluded: on release it must not be re-granted,
  // and on preemption only the other channels compete.
  assign mask     = (state == ST_OWN) ? ~gnt : '1;
  // Scanning restarts just past the owner; fixed-priority always scans from 0.
  assign pick_ptr = (RR_MODE == 0) ? '0 :
                    (state == ST_OWN) ? next_idx(gnt_id) : ptr;
  assign at_limit = (MAX_HOLD != 0) && (hold_cnt >= HOLD_LAST);

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .mask   (mask),
    .win    (win),
    .win_id (win_id),
    .any    (any)
  );

  // Decide whether the next edge hands the port to a new channel.
  always_comb begin
    do_grant   = 1'b0;
    do_preempt = 1'b0;
    case (state)
      ST_IDLE: do_grant = any;
      ST_OWN: begin
        if (released) begin
          do_grant = any;
        end else if (at_limit && any) begin
          do_grant   = 1'b1;
          do_preempt = 1'b1;
        end
      end
      default: do_grant = 1'b0;
    endcase
  end

  // Registered grant state, round-robin pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      preempt   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      preempt <= do_preempt;
      if (do_grant) begin
        gnt       <= win;
        gnt_valid <= 1'b1;
        gnt_id    <= win_id;
        ptr       <= next_idx(win_id);
        hold_cnt  <= '0;
      end else if (state == ST_OWN && released) begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
        hold_cnt  <= '0;
      end else if (state == ST_OWN && hold_cnt < HOLD_MAX) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Bench for rr_hold_arbiter: three instances (round-robin MAX_HOLD=16,
// fixed-priority MAX_HOLD=16, round-robin MAX_HOLD=4) share one request
// stream. A reference model predicts each instance's outputs per edge and
// queues them; a monitor pops and compares after each edge.
module tb_rr_hold_arbiter;
  import noc_arb_pkg::*;

  typedef struct packed {
    logic [4:0] gnt;
    logic [2:0] id;
    logic       v;
    logic       p;
  } exp_t;

  typedef struct packed {
    int          tag;
    exp_t [2:0]  e;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] req = '0;
  logic [4:0] gnt_a [3];
  logic       v_a   [3];
  logic [2:0] id_a  [3];
  logic       p_a   [3];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ent_t sb [$];

  // Reference model state per instance: owner (-1 = idle), rr pointer, hold.
  int m_owner [3] = '{-1, -1, -1};
  int m_ptr   [3] = '{0, 0, 0};
  int m_hold  [3] = '{0, 0, 0};
  int cfg_rr  [3] = '{1, 0, 1};
  int cfg_mh  [3] = '{16, 16, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rr_hold_arbiter #(.NUM_REQ(5), .ID_W(3), .MAX_HOLD(16), .RR_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[0]), .gnt_valid(v_a[0]),
    .gnt_id(id_a[0]), .preempt(p_a[0]));
  rr_hold_arbiter #(.NUM_REQ(5), .ID_W(3), .MAX_HOLD(16), .RR_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[1]), .gnt_valid(v_a[1]),
    .gnt_id(id_a[1]), .preempt(p_a[1]));
  rr_hold_arbiter #(.NUM_REQ(5), .ID_W(3), .MAX_HOLD(4), .RR_MODE(1)) u_lim (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_a[2]), .gnt_valid(v_a[2]),
    .gnt_id(id_a[2]), .preempt(p_a[2]));

  // First asserted channel scanning start, start+1, ... modulo 5.
  function automatic int pick(input logic [4:0] r, input int start);
    for (int i = 0; i < 5; i++) begin
      if (r[(start + i) % 5]) return (start + i) % 5;
    end
    return -1;
  endfunction

  function automatic void take(input int d, input int w);
    m_owner[d] = w;
    m_hold[d]  = 0;
    m_ptr[d]   = (w + 1) % 5;
  endfunction

  // Advance instance d's model across one clock edge; return expected outputs.
  function automatic exp_t step(input int d, input logic [4:0] r, input bit rn);
    exp_t e;
    logic [4:0] others;
    int w;
    int start;
    e = '0;
    if (!rn) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_hold[d]  = 0;
    end else if (m_owner[d] < 0) begin
      w = pick(r, (cfg_rr[d] != 0) ? m_ptr[d] : 0);
      if (w >= 0) take(d, w);
    end else begin
      others = r;
      others[m_owner[d]] = 1'b0;
      start = (cfg_rr[d] != 0) ? (m_owner[d] + 1) % 5 : 0;
      if (!r[m_owner[d]]) begin
        w = pick(others, start);
        if (w >= 0) take(d, w);
        else m_owner[d] = -1;
      end else if (cfg_mh[d] != 0 && m_hold[d] >= cfg_mh[d] - 1 && others != 0) begin
        take(d, pick(others, start));
        e.p = 1'b1;
      end else if (m_hold[d] < cfg_mh[d]) begin
        m_hold[d]++;
      end
    end
    e.v   = (m_owner[d] >= 0);
    e.gnt = e.v ? 5'(1 << m_owner[d]) : 5'b0;
    e.id  = e.v ? 3'(m_owner[d]) : 3'b0;
    return e;
  endfunction

  // Apply one cycle of stimulus just after an edge and queue the prediction.
  task automatic drive(input logic [4:0] r, input bit rn);
    ent_t en;
    @(posedge clk);
    #2;
    req = r;
    if (!rn && rst_n) begin
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
        total++;
        if (gnt_a[d] != 0 || v_a[d] || id_a[d] != 0 || p_a[d]) begin
          bad++;
          $display("FAIL async_reset dut%0d: gnt=%b valid=%b id=%0d preempt=%b, required all zero",
                   d, gnt_a[d], v_a[d], id_a[d], p_a[d]);
        end
      end
    end else begin
      rst_n = rn;
    end
    en.tag = cyc + 1;
    for (int d = 0; d < 3; d++) en.e[d] = step(d, r, rn);
    sb.push_back(en);
  endtask

  // Monitor: after each edge compare every prediction whose edge has passed.
  initial begin
    ent_t en;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        en = sb.pop_front();
        for (int d = 0; d < 3; d++) begin
          act = '{gnt: gnt_a[d], id: id_a[d], v: v_a[d], p: p_a[d]};
          total++;
          if (act != en.e[d]) begin
            bad++;
            $display("FAIL outputs dut%0d edge%0d: gnt=%b id=%0d valid=%b preempt=%b, required gnt=%b id=%0d valid=%b preempt=%b",
                     d, en.tag, act.gnt, act.id, act.v, act.p,
                     en.e[d].gnt, en.e[d].id, en.e[d].v, en.e[d].p);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] r;

    // Reset then idle.
    for (int i = 0; i < 3; i++) drive(5'b00000, 1'b0);
    for (int i = 0; i < 5; i++) drive(5'b00000, 1'b1);

    // Single request held 6 cycles, then dropped.
    for (int i = 0; i < 6; i++) drive(5'b00100, 1'b1);
    for (int i = 0; i < 3; i++) drive(5'b00000, 1'b1);

    // Round-robin rotation: everyone requests, owner drops for one cycle after 3.
    drive(5'b00000, 1'b0);
    for (int i = 0; i < 22; i++) begin
      r = 5'b11111;
      if (m_owner[0] >= 0 && m_hold[0] >= 2) r[m_owner[0]] = 1'b0;
      drive(r, 1'b1);
    end

    // Fixed-priority release: channel 1 leaves, 2 and 4 still waiting.
    drive(5'b00000, 1'b0);
    for (int i = 0; i < 3; i++) drive(5'b10110, 1'b1);
    for (int i = 0; i < 3; i++) drive(5'b10100, 1'b1);
    drive(5'b00000, 1'b1);

    // Hold limit: channel 0 long-running, channel 3 arrives and later leaves.
    drive(5'b00000, 1'b0);
    r = '0;
    r[LOCAL] = 1'b1;
    for (int i = 0; i < 2; i++) drive(r, 1'b1);
    r[SOUTH] = 1'b1;
    for (int i = 0; i < 8; i++) drive(r, 1'b1);
    r[SOUTH] = 1'b0;
    for (int i = 0; i < 10; i++) drive(r, 1'b1);
    drive(5'b00000, 1'b1);

    // Async reset while channel 1 (NORTH) owns the port.
    r = '0;
    r[NORTH] = 1'b1;
    for (int i = 0; i < 3; i++) drive(r, 1'b1);
    drive(r, 1'b0);
    drive(5'b00000, 1'b0);
    for (int i = 0; i < 3; i++) drive(5'b00011, 1'b1);
    r[EAST] = 1'b1;
    r[WEST] = 1'b1;
    for (int i = 0; i < 3; i++) drive(r, 1'b1);

    // Randomised sticky requests with occasional owner release.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      if (m_owner[0] >= 0 && $urandom_range(0, 7) == 0) r[m_owner[0]] = 1'b0;
      drive(r, (i == 300) ? 1'b0 : 1'b1);
    end

    for (int i = 0; i < 3; i++) drive(5'b00000, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
